// File: rtl/mmio_data_mem.sv
// Data memory plus MMIO block for the RV32 MEM/WB stages.
//
// Byte-enabled RAM with a 1-cycle synchronous read and load formatting, a readable
// LED register, a FIFO-buffered 8N1 UART transmitter, a free-running cycle counter
// and explicit misaligned-access flags.
//
// Ports:
//   clk, rst          system clock (rising edge), asynchronous active-high reset
//   MemRead/MemWrite  load / store request this cycle
//   be                store byte enables, already lane-positioned
//   funct3            access size/sign (LB, LH, LW, LBU, LHU)
//   Address           byte address
//   WriteData         store data, LSB-aligned
//   ReadData          formatted load data for the access captured on the previous edge
//   load_misaligned   pulse aligned with ReadData
//   store_misaligned  pulse the cycle after an offending store
//   leds_out          LED register
//   uart_tx_wire      serial TX, idle high
//
// MMIO map (word offsets from MMIO_BASE): +0 LED, +4 UART TX data, +8 UART status,
// +C cycle counter. Status: bit0 busy, bit1 full, bit2 empty, bit3 overflow,
// bits[15:8] FIFO count.
module mmio_data_mem #(
  parameter int unsigned DEPTH_WORDS   = 1048576,
  parameter logic [31:0] MMIO_BASE     = 32'h8000_0000,
  parameter int unsigned LED_WIDTH     = 4,
  parameter int unsigned TX_FIFO_DEPTH = 16,
  parameter int unsigned CLKS_PER_BIT  = 868
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [3:0]           be,
  input  logic [2:0]           funct3,
  input  logic [31:0]          Address,
  input  logic [31:0]          WriteData,
  output logic [31:0]          ReadData,
  output logic                 load_misaligned,
  output logic                 store_misaligned,
  output logic [LED_WIDTH-1:0] leds_out,
  output logic                 uart_tx_wire
);

  localparam int unsigned IdxW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned FifoAw  = $clog2(TX_FIFO_DEPTH);
  localparam int unsigned FifoCw  = FifoAw + 1;
  localparam int unsigned ClkCntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [63:0] RamBytes = 64'(DEPTH_WORDS) << 2;
  localparam logic [ClkCntW-1:0] ClkCntMax = ClkCntW'(CLKS_PER_BIT - 1);
  localparam logic [FifoCw-1:0]  FifoFull  = FifoCw'(TX_FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

  // ---------------------------------------------------------------------------
  // Address decode and alignment
  // ---------------------------------------------------------------------------
  logic [1:0]      offset;
  logic            is_half, is_word, misaligned;
  logic            in_ram, in_mmio, mmio_sel;
  logic [29:0]     mmio_rel;
  logic [1:0]      mmio_reg;
  logic [IdxW-1:0] ram_idx;

  always_comb begin
    offset     = Address[1:0];
    is_half    = (funct3[1:0] == 2'b01);
    is_word    = funct3[1];
    // Half accesses at offset 1 stay inside the word, so only offset 3 faults.
    misaligned = (is_half && (offset == 2'd3)) || (is_word && (offset != 2'd0));
    in_ram     = ({32'd0, Address} < RamBytes);
    mmio_rel   = Address[31:2] - MMIO_BASE[31:2];
    in_mmio    = (Address[31:2] >= MMIO_BASE[31:2]) && (mmio_rel[29:2] == '0);
    mmio_sel   = in_mmio && !in_ram;
    mmio_reg   = mmio_rel[1:0];
    ram_idx    = in_ram ? Address[IdxW+1:2] : '0;
  end

  logic wr_ok, rd_ok;
  assign wr_ok = MemWrite && !misaligned;
  assign rd_ok = MemRead && !misaligned;

  logic ram_we, led_we, tx_push, status_rd;
  assign ram_we    = wr_ok && in_ram;
  assign led_we    = wr_ok && mmio_sel && (mmio_reg == 2'd0);
  assign tx_push   = wr_ok && mmio_sel && (mmio_reg == 2'd1);
  assign status_rd = rd_ok && mmio_sel && (mmio_reg == 2'd2);

  // ---------------------------------------------------------------------------
  // RAM: byte-lane writes, word registered every cycle (read-before-write)
  // ---------------------------------------------------------------------------
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] wdata_sh;
  logic [31:0] ram_word_q;

  assign wdata_sh = WriteData << {offset, 3'b000};

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[ram_idx][8*k +: 8] <= wdata_sh[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ram_word_q <= '0;
    else     ram_word_q <= mem[ram_idx];
  end

  // ---------------------------------------------------------------------------
  // LED register and cycle counter
  // ---------------------------------------------------------------------------
  logic [LED_WIDTH-1:0] led_q;
  logic [31:0]          cyc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= '0;
      cyc_q <= '0;
    end else begin
      if (led_we) led_q <= WriteData[LED_WIDTH-1:0];
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign leds_out = led_q;

  // ---------------------------------------------------------------------------
  // UART TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]        fifo_mem [TX_FIFO_DEPTH];
  logic [FifoAw-1:0] wr_ptr_q, rd_ptr_q;
  logic [FifoCw-1:0] count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              fifo_full, fifo_empty, push_ok, tx_pop;

  assign fifo_full  = (count_q == FifoFull);
  assign fifo_empty = (count_q == '0);
  // Fullness uses the pre-edge count, so a simultaneous pop does not save a push.
  assign push_ok    = tx_push && !fifo_full;

  always_comb begin
    count_d = count_q + {{FifoAw{1'b0}}, push_ok} - {{FifoAw{1'b0}}, tx_pop};
    overflow_d = overflow_q;
    if (status_rd)            overflow_d = 1'b0;
    // An overflowing push on the same edge as a status read keeps the flag set.
    if (tx_push && fifo_full) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= WriteData[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (tx_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // 8N1 serialiser
  // ---------------------------------------------------------------------------
  tx_state_e          state_q, state_d;
  logic [ClkCntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               bit_end, tx_busy;

  assign bit_end = (clk_cnt_q == ClkCntMax);
  assign tx_busy = (state_q != StIdle);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_pop    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          tx_pop    = 1'b1;
          shift_d   = fifo_mem[rd_ptr_q];
          clk_cnt_d = '0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = 3'd0;
          state_d   = StData;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      StData: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = StStop;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = StIdle;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Line decoded from state so an asynchronous reset returns it high at once.
  always_comb begin
    uart_tx_wire = 1'b1;
    unique case (state_q)
      StStart: uart_tx_wire = 1'b0;
      StData:  uart_tx_wire = shift_q[0];
      default: uart_tx_wire = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // MMIO read mux and read-path capture
  // ---------------------------------------------------------------------------
  logic [31:0] status_word, mmio_rdata;

  assign status_word = {16'h0000, 8'(count_q), 4'h0, overflow_q, fifo_empty, fifo_full,
                        tx_busy};

  always_comb begin
    mmio_rdata = '0;
    unique case (mmio_reg)
      2'd0:    mmio_rdata = 32'(led_q);
      2'd2:    mmio_rdata = status_word;
      2'd3:    mmio_rdata = cyc_q;
      default: mmio_rdata = '0;
    endcase
  end

  logic        rd_ram_q, rd_mmio_q, rd_mis_q, st_mis_q;
  logic [2:0]  rd_funct3_q;
  logic [1:0]  rd_off_q;
  logic [31:0] mmio_word_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ram_q    <= 1'b0;
      rd_mmio_q   <= 1'b0;
      rd_mis_q    <= 1'b0;
      st_mis_q    <= 1'b0;
      rd_funct3_q <= '0;
      rd_off_q    <= '0;
      mmio_word_q <= '0;
    end else begin
      rd_ram_q    <= rd_ok && in_ram;
      rd_mmio_q   <= rd_ok && mmio_sel;
      rd_mis_q    <= MemRead && misaligned;
      st_mis_q    <= MemWrite && misaligned;
      rd_funct3_q <= funct3;
      rd_off_q    <= offset;
      mmio_word_q <= mmio_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Load formatting from registered state
  // ---------------------------------------------------------------------------
  logic [31:0] word_sel, word_sh;

  always_comb begin
    word_sel = '0;
    if (rd_ram_q)       word_sel = ram_word_q;
    else if (rd_mmio_q) word_sel = mmio_word_q;
    word_sh = word_sel >> {rd_off_q, 3'b000};
    ReadData = word_sel;
    case (rd_funct3_q)
      3'b000:  ReadData = {{24{word_sh[7]}}, word_sh[7:0]};
      3'b001:  ReadData = {{16{word_sh[15]}}, word_sh[15:0]};
      3'b100:  ReadData = {24'h000000, word_sh[7:0]};
      3'b101:  ReadData = {16'h0000, word_sh[15:0]};
      default: ReadData = word_sel;
    endcase
    if (rd_mis_q) ReadData = '0;
  end

  assign load_misaligned  = rd_mis_q;
  assign store_misaligned = st_mis_q;

endmodule

// File: tb/tb_mmio_data_mem.sv
module tb_mmio_data_mem;

  localparam int unsigned DepthWords = 1024;
  localparam int unsigned LedWidth   = 4;
  localparam int unsigned FifoDepth  = 4;
  localparam int unsigned Cpb        = 4;
  localparam logic [31:0] Base       = 32'h8000_0000;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  logic                clk = 1'b0;
  logic                rst;
  logic                MemRead, MemWrite;
  logic [3:0]          be;
  logic [2:0]          funct3;
  logic [31:0]         Address, WriteData;
  logic [31:0]         ReadData;
  logic                load_misaligned, store_misaligned;
  logic [LedWidth-1:0] leds_out;
  logic                uart_tx_wire;

  mmio_data_mem #(
    .DEPTH_WORDS  (DepthWords),
    .MMIO_BASE    (Base),
    .LED_WIDTH    (LedWidth),
    .TX_FIFO_DEPTH(FifoDepth),
    .CLKS_PER_BIT (Cpb)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .MemRead         (MemRead),
    .MemWrite        (MemWrite),
    .be              (be),
    .funct3          (funct3),
    .Address         (Address),
    .WriteData       (WriteData),
    .ReadData        (ReadData),
    .load_misaligned (load_misaligned),
    .store_misaligned(store_misaligned),
    .leds_out        (leds_out),
    .uart_tx_wire    (uart_tx_wire)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Load scoreboard: expectations pushed when a load is driven.
  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        mis;
  } ld_exp_t;

  ld_exp_t    exp_q[$];
  logic [7:0] tx_exp[$];
  logic       rd_issued;

  always @(posedge clk or posedge rst) begin
    if (rst) rd_issued <= 1'b0;
    else     rd_issued <= MemRead;
  end

  always @(negedge clk) begin
    if (rd_issued) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        ld_exp_t e;
        e = exp_q.pop_front();
        check(e.tag, ReadData, e.data);
        check({e.tag, "_mis"}, 32'(load_misaligned), 32'(e.mis));
      end
    end
  end

  // Serial receiver: decodes 8N1 frames and checks them against tx_exp.
  logic rx_en = 1'b1;
  logic burst_on = 1'b0;
  logic have_prev = 1'b0;
  time  t_start, t_prev;

  initial begin
    logic [7:0] rx_byte;
    logic       sb, stop_b;
    forever begin
      @(negedge uart_tx_wire);
      if (!rst) begin
        t_start = $time;
        if (burst_on) begin
          if (have_prev) check("frame_gap", 32'(t_start - t_prev), 32'd410);
          t_prev    = t_start;
          have_prev = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1 sb = uart_tx_wire;
        for (int i = 0; i < 8; i++) begin
          repeat (Cpb) @(posedge clk);
          #1 rx_byte[i] = uart_tx_wire;
        end
        repeat (Cpb) @(posedge clk);
        #1 stop_b = uart_tx_wire;
        if (rx_en) begin
          check("rx_start_bit", 32'(sb), 32'd0);
          check("rx_stop_bit", 32'(stop_b), 32'd1);
          if (tx_exp.size() == 0) check("rx_unexpected", 32'(rx_byte), 32'h100);
          else                    check("rx_byte", 32'(rx_byte), 32'(tx_exp.pop_front()));
        end
      end
    end
  end

  logic watch_line = 1'b0;
  logic low_seen = 1'b0;
  always @(posedge clk) begin
    if (watch_line && !uart_tx_wire) low_seen <= 1'b1;
  end

  task automatic op(input logic rd, input logic wr, input logic [3:0] b, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd);
    MemRead   = rd;
    MemWrite  = wr;
    be        = b;
    funct3    = f3;
    Address   = a;
    WriteData = wd;
    @(posedge clk);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    op(1'b0, 1'b1, 4'hF, F3Lw, a, d);
  endtask

  task automatic ld(input string tag, input logic [31:0] a, input logic [2:0] f3,
                    input logic [31:0] exp, input logic mis);
    exp_q.push_back('{tag, exp, mis});
    op(1'b1, 1'b0, 4'h0, f3, a, 32'h0);
  endtask

  initial begin
    logic [9:0] frame;
    logic [7:0] burst [6];
    burst = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'h0F, 8'hF0};

    rst = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; be = 4'h0; funct3 = 3'b000;
    Address = 32'h0; WriteData = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_readdata", ReadData, 32'h0);
    check("rst_load_mis", 32'(load_misaligned), 32'd0);
    check("rst_store_mis", 32'(store_misaligned), 32'd0);
    check("rst_leds", 32'(leds_out), 32'h0);
    check("rst_tx_line", 32'(uart_tx_wire), 32'd1);
    rst = 1'b0;
    ld("rst_status", Base + 32'h8, F3Lw, 32'h0000_0004, 1'b0);

    // Load formatting on a known word
    sw(32'h100, 32'hA1B2_C3D4);
    check("sw_no_mis", 32'(store_misaligned), 32'd0);
    ld("lb0",  32'h100, F3Lb,  32'hFFFF_FFD4, 1'b0);
    ld("lb1",  32'h101, F3Lb,  32'hFFFF_FFC3, 1'b0);
    ld("lb2",  32'h102, F3Lb,  32'hFFFF_FFB2, 1'b0);
    ld("lb3",  32'h103, F3Lb,  32'hFFFF_FFA1, 1'b0);
    ld("lbu0", 32'h100, F3Lbu, 32'h0000_00D4, 1'b0);
    ld("lbu1", 32'h101, F3Lbu, 32'h0000_00C3, 1'b0);
    ld("lbu2", 32'h102, F3Lbu, 32'h0000_00B2, 1'b0);
    ld("lbu3", 32'h103, F3Lbu, 32'h0000_00A1, 1'b0);
    ld("lh0",  32'h100, F3Lh,  32'hFFFF_C3D4, 1'b0);
    ld("lh1",  32'h101, F3Lh,  32'hFFFF_B2C3, 1'b0);
    ld("lh2",  32'h102, F3Lh,  32'hFFFF_A1B2, 1'b0);
    ld("lhu0", 32'h100, F3Lhu, 32'h0000_C3D4, 1'b0);
    ld("lhu2", 32'h102, F3Lhu, 32'h0000_A1B2, 1'b0);
    ld("lhu3", 32'h103, F3Lhu, 32'h0000_0000, 1'b1);
    ld("lw",   32'h100, F3Lw,  32'hA1B2_C3D4, 1'b0);

    // Half store into upper lanes, misaligned store and load
    op(1'b0, 1'b1, 4'b1100, F3Lh, 32'h102, 32'h0000_1234);
    ld("lw_after_sh", 32'h100, F3Lw, 32'h1234_C3D4, 1'b0);
    sw(32'h101, 32'hDEAD_BEEF);
    check("st_mis_pulse", 32'(store_misaligned), 32'd1);
    idle(1);
    check("st_mis_clear", 32'(store_misaligned), 32'd0);
    ld("lw_after_missw", 32'h100, F3Lw, 32'h1234_C3D4, 1'b0);
    ld("lw_mis", 32'h102, F3Lw, 32'h0000_0000, 1'b1);
    ld("lw_ok", 32'h100, F3Lw, 32'h1234_C3D4, 1'b0);

    // Read-before-write on the same word, and out-of-range accesses
    sw(32'h200, 32'h1111_1111);
    exp_q.push_back('{"rbw_old", 32'h1111_1111, 1'b0});
    op(1'b1, 1'b1, 4'hF, F3Lw, 32'h200, 32'h2222_2222);
    ld("rbw_new", 32'h200, F3Lw, 32'h2222_2222, 1'b0);
    sw(32'h0, 32'h0000_0000);
    sw(32'h1000, 32'hFFFF_FFFF);
    ld("oor_read", 32'h1000, F3Lw, 32'h0, 1'b0);
    ld("oor_no_alias", 32'h0, F3Lw, 32'h0, 1'b0);

    // LED register and unmapped MMIO
    sw(Base, 32'h0000_00FF);
    check("leds_write", 32'(leds_out), 32'hF);
    ld("led_read", Base, F3Lw, 32'h0000_000F, 1'b0);
    ld("txdata_read", Base + 32'h4, F3Lw, 32'h0, 1'b0);
    sw(Base + 32'h10, 32'h0);
    check("leds_unmapped_wr", 32'(leds_out), 32'hF);
    ld("mmio_unmapped", Base + 32'h10, F3Lw, 32'h0, 1'b0);

    // Single UART frame, sampled mid-bit
    frame = {1'b1, 8'h55, 1'b0};
    tx_exp.push_back(8'h55);
    sw(Base + 32'h4, 32'h0000_0055);
    idle(2);
    check("uart_bit0", 32'(uart_tx_wire), 32'(frame[0]));
    for (int k = 1; k < 10; k++) begin
      if (k == 3) begin
        ld("status_busy", Base + 32'h8, F3Lw, 32'h0000_0005, 1'b0);
        idle(3);
      end else begin
        idle(4);
      end
      check($sformatf("uart_bit%0d", k), 32'(uart_tx_wire), 32'(frame[k]));
    end
    idle(4);
    ld("status_idle", Base + 32'h8, F3Lw, 32'h0000_0004, 1'b0);

    // Overflow: six pushes into a four-entry FIFO behind a busy serialiser
    have_prev = 1'b0;
    burst_on  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) tx_exp.push_back(burst[i]);
      sw(Base + 32'h4, 32'(burst[i]));
    end
    ld("status_ovf", Base + 32'h8, F3Lw, 32'h0000_040B, 1'b0);
    ld("status_ovf_clr", Base + 32'h8, F3Lw, 32'h0000_0403, 1'b0);
    idle(260);
    burst_on = 1'b0;
    check("tx_all_received", 32'(tx_exp.size()), 32'd0);

    // Asynchronous reset mid-frame
    rx_en = 1'b0;
    sw(Base + 32'h4, 32'h0000_003C);
    sw(Base + 32'h4, 32'h0000_00C3);
    idle(10);
    check("pre_rst_busy_line", 32'(uart_tx_wire), 32'(1'b0 ^ uart_tx_wire));
    rst = 1'b1;
    #1;
    check("rst_mid_line", 32'(uart_tx_wire), 32'd1);
    check("rst_mid_leds", 32'(leds_out), 32'h0);
    check("rst_mid_readdata", ReadData, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    ld("cyc_restart", Base + 32'hC, F3Lw, 32'h0, 1'b0);
    idle(3);
    ld("cyc_count", Base + 32'hC, F3Lw, 32'h4, 1'b0);
    ld("status_after_rst", Base + 32'h8, F3Lw, 32'h0000_0004, 1'b0);
    watch_line = 1'b1;
    idle(60);
    check("no_frame_after_rst", 32'(low_seen), 32'd0);
    idle(2);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
